// File: rtl/frame_acc_pkg.sv
// Shared definitions for frame_accumulator: FSM state type, counter width
// helper and the all-ones constant used when saturation is compiled in.
package frame_acc_pkg;

  // Widest operand the all-ones generator supports.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Beat counter width; a floor of 1 keeps the register legal for tiny COUNT.
  function automatic int unsigned cnt_w(input int unsigned count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

  // All-ones pattern of the requested width, zero above it.
  function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_accumulator_adder.sv
// Parametric ripple-carry adder. Kept as a bit-serial carry chain so the
// critical path is the explicit WIDTH-bit ripple.
module adder #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  // Full-adder cells chained LSB to MSB.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/frame_accumulator.sv
// Frame accumulator: sums COUNT unsigned operands per frame through the
// ripple-carry adder and presents the total plus a sticky carry-out flag on
// a valid/ready output. Optional macro FRAME_ACCUMULATOR_SATURATE_EN clamps
// the running sum to all-ones on carry-out instead of wrapping.
import frame_acc_pkg::*;

module frame_accumulator #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned    CW   = cnt_w(COUNT);
  localparam logic [CW-1:0]  LAST = CW'(COUNT - 1);
`ifdef FRAME_ACCUMULATOR_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT = WIDTH'(all_ones(WIDTH));
`endif

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] acc_nxt;
  logic             ovf_nxt;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Handshake outputs decode the state register only (no path from out_ready).
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);

  // Next accumulator value: wrapped sum, or clamped when saturation is built in.
  always_comb begin
    ovf_nxt = ovf | add_cout;
`ifdef FRAME_ACCUMULATOR_SATURATE_EN
    acc_nxt = add_cout ? SAT : add_sum;
`else
    acc_nxt = add_sum;
`endif
  end

  // Frame FSM, accumulator, beat counter and output result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      // Abort: drop partial frame or pending result; out_sum keeps last load.
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc <= acc_nxt;
            ovf <= ovf_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state   <= ST_HOLD;
              out_sum <= acc_nxt;
              out_ovf <= ovf_nxt;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Scoreboard bench for frame_accumulator (WIDTH=12, COUNT=4). A reference
// model collects accepted operands per frame and computes the expected total
// with plain integer arithmetic; a monitor checks every output cycle.
module tb_frame_accumulator;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned COUNT = 4;
`ifdef FRAME_ACCUMULATOR_SATURATE_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             clear = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;

  frame_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] beats[$];
  bit               m_hold = 1'b0;
  int unsigned      n_tests = 0;
  int unsigned      n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame total from the list of operands: exact integer sum, then wrap or clamp.
  function automatic exp_t frame_result();
    exp_t        e;
    int unsigned total = 0;
    foreach (beats[i]) total += beats[i];
    e.ovf = (total >= (1 << WIDTH));
    if (SAT_MODE && e.ovf) e.sum = '1;
    else                   e.sum = WIDTH'(total % (1 << WIDTH));
    return e;
  endfunction

  // Reference model: tracks the frame in progress and whether a result is held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats.delete();
      exp_q.delete();
      m_hold = 1'b0;
    end else if (clear) begin
      beats.delete();
      if (m_hold) begin
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        m_hold = 1'b0;
      end
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      beats.push_back(in_data);
      if (beats.size() == COUNT) begin
        exp_q.push_back(frame_result());
        beats.delete();
        m_hold = 1'b1;
      end
    end
  end

  // Monitor: handshake levels every cycle, result contents whenever presented.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!m_hold));
      check("out_valid", 32'(out_valid), 32'(m_hold));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          check("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
          check("out_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
          if (out_ready) exp_q.delete(0);
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit c, input bit r);
    in_valid  = v;
    in_data   = d;
    clear     = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit               v, c, r;
    logic [WIDTH-1:0] d;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1,2,3,4
    cyc(1, 12'd1, 0, 1);
    cyc(1, 12'd2, 0, 1);
    cyc(1, 12'd3, 0, 1);
    cyc(1, 12'd4, 0, 1);
    cyc(0, 12'd0, 0, 1);
    cyc(0, 12'd0, 0, 0);

    // Overflow
    cyc(1, 12'hFFF, 0, 0);
    cyc(1, 12'h002, 0, 0);
    cyc(1, 12'h000, 0, 0);
    cyc(1, 12'h000, 0, 0);
    cyc(0, 12'd0, 0, 1);

    // Backpressure: result held for 5 cycles
    for (int i = 0; i < 4; i++) cyc(1, 12'h010, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 12'd0, 0, 0);
    cyc(0, 12'd0, 0, 1);

    // Input gaps
    for (int i = 0; i < 4; i++) begin
      cyc(1, 12'h100, 0, 0);
      cyc(0, 12'hABC, 0, 0);
    end
    cyc(0, 12'd0, 0, 1);

    // Clear mid-frame, beat in the clear cycle discarded
    cyc(1, 12'h7FF, 0, 0);
    cyc(1, 12'h7FF, 0, 0);
    cyc(1, 12'h7FF, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 12'h005, 0, 0);
    cyc(0, 12'd0, 0, 1);

    // Asynchronous reset between edges after 3 beats
    for (int i = 0; i < 3; i++) cyc(1, 12'h123, 0, 0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_sum", 32'(out_sum), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(1, 12'd1, 0, 0);
    cyc(0, 12'd0, 0, 1);

    // Randomized traffic with backpressure and occasional clear
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 255));
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 24) == 0) && !(m_hold && r);
      cyc(v, d, c, r);
    end
    for (int i = 0; i < 3; i++) cyc(0, 12'd0, 0, 1);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_accumulator.md
# frame_accumulator

- Sequential accumulation stage built around the team's parametric ripple-carry `adder`.
- Accepts a stream of WIDTH-bit unsigned operands over a valid/ready handshake and sums exactly COUNT operands per frame.
- Presents each frame total, plus an overflow flag, on a valid/ready output.
- Sits downstream of the operand source and upstream of result consumers.
- Turns the combinational adder into a frame-based sum engine.

## Interface
- WIDTH, 12: operand and sum width in bits.
- COUNT, 8: operands per frame; legal range 2..2^16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  unsigned operand.
- clear  input  1  synchronous frame abort.
- out_valid  output  1  frame result present.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  frame total.
- out_ovf  output  1  at least one carry-out occurred during the frame.

Reset and clocking: one clock; reset is asynchronous and active-low.

## Operation
- States: ACC and HOLD.
- Reset state: ACC with acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, out_sum=0, out_ovf=0.
- ACC:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On acceptance: acc <= adder(acc, in_data, Cin=0).Sum, ovf <= ovf | Cout, cnt <= cnt+1.
  - When the accepted beat is the COUNT-th (cnt == COUNT-1), the next state is HOLD.
  - Entering HOLD loads out_sum and out_ovf from the final acc and ovf values.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum and out_ovf stay stable until the handshake completes.
  - When out_ready=1, the block returns to ACC with acc=0, cnt=0, ovf=0, out_valid=0.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH unless the saturation feature is compiled in.
  - cnt width is clog2(COUNT).
- clear:
  - Highest priority below reset.
  - Effective in either state; next cycle is ACC with acc=0, cnt=0, ovf=0, out_valid=0.
  - An input beat presented in the same cycle is discarded.
  - A pending HOLD result is dropped.
- in_valid gaps:
  - cnt and acc hold their values.
  - There is no timeout.
- Reset asserted mid-frame: all state returns to the reset values immediately. A partial frame is never emitted.
- in_data is don't-care when in_valid=0. out_sum is don't-care when out_valid=0, but must be deterministic (the last loaded value).

## Timing
- Latency: the COUNT-th beat accepted at edge N gives out_valid=1 after edge N, visible in cycle N+1.
- Minimum frame period is COUNT+1 cycles (COUNT accept cycles plus one HOLD cycle with out_ready=1).
- in_ready is a pure function of the state register, with no combinational path from out_ready. in_ready is re-asserted in the cycle after the output handshake.
- out_valid must never drop without either an out_ready handshake or clear/reset.
- The adder path is combinational within one cycle. The critical path is the WIDTH-bit ripple.

## Configuration
- Macro: FRAME_ACCUMULATOR_SATURATE_EN.
- Defined:
  - On any Cout=1, acc becomes all-ones (2^WIDTH-1) instead of the wrapped Sum.
  - Later beats keep acc at all-ones.
  - ovf is set exactly as in wrap mode.
- Undefined: acc wraps modulo 2^WIDTH; ovf is sticky.

## Structure
- Shared package frame_acc_pkg holds:
  - the state enum (ST_ACC, ST_HOLD);
  - a clog2-based CNT_W helper;
  - the saturation constant generator (all-ones of WIDTH).
- One sub-module: the existing `adder` with WIDTH passed through and Cin tied to 0. Its Cout feeds the ovf and saturation logic.
- All registers and the FSM live in frame_accumulator.

## Test plan
All scenarios use WIDTH=12 and COUNT=4.
- Basic frame: operands 1,2,3,4 on back-to-back cycles with out_ready=1 -> out_valid one cycle after the 4th beat, out_sum=0x00A, out_ovf=0, in_ready high again in the following cycle.
- Overflow: operands 0xFFF,0x002,0x000,0x000 -> wrap build gives out_sum=0x001, out_ovf=1. With FRAME_ACCUMULATOR_SATURATE_EN: out_sum=0xFFF, out_ovf=1.
- Backpressure: complete a frame of 4×0x010 and hold out_ready=0 for 5 cycles -> out_valid stays 1, out_sum=0x040 stable, in_ready=0 throughout; raising out_ready completes the handshake in that cycle.
- Input gaps: 4 beats of 0x100 with in_valid toggling every other cycle -> out_sum=0x400, with acc unchanged during the idle cycles.
- Clear mid-frame: 2 beats of 0x7FF, then clear together with a third beat, then 4 beats of 0x005 -> out_sum=0x014, out_ovf=0.
- Async reset mid-frame: rst_n pulsed low between edges after 3 beats -> out_valid=0 and in_ready=1 immediately. A following frame of 1,1,1,1 gives out_sum=0x004.
